// File: rtl/dm_subword_if.sv
// Data-memory bus between the MEM stage and dm_subword.
// Master drives requests; slave returns load data and status.
interface dm_subword_if;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        addr_err;

  modport master (
    output MemWrite, MemRead, MemOp, addr, din,
    input  dout, busy, addr_err
  );

  modport slave (
    input  MemWrite, MemRead, MemOp, addr, din,
    output dout, busy, addr_err
  );
endinterface

// File: rtl/dm_subword.sv
// Sub-word data memory: byte/half/word stores with lane merge,
// extended loads, misalignment flag, sequential clear on reset.
module dm_subword #(
  parameter int DEPTH_LOG2 = 10
) (
  input logic         clk,
  input logic         reset,
  dm_subword_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           w;
  logic [15:0]           half_v;
  logic [7:0]            byte_v;
  logic                  is_half, is_byte, is_sgn;
  logic                  mis, ready;
  logic                  clr_we, st_we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           dout_d;
  logic                  unused_addr;

  assign idx  = bus.addr[DEPTH_LOG2+1:2];
  assign lane = bus.addr[1:0];
  assign w    = mem_q[idx];
  assign unused_addr = ^bus.addr[31:DEPTH_LOG2+2];

  assign ready   = (state_q == READY);
  assign is_half = (bus.MemOp == 3'b001) || (bus.MemOp == 3'b010);
  assign is_byte = (bus.MemOp == 3'b011) || (bus.MemOp == 3'b100);
  assign is_sgn  = (bus.MemOp == 3'b010) || (bus.MemOp == 3'b100);

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      is_byte: mis = 1'b0;
      is_half: mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
  end

  assign clr_we = !reset && (state_q == CLEAR);
  assign st_we  = !reset && ready && bus.MemWrite && !mis;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      if (&clr_ptr_q) begin
        state_d = READY;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Lane enables and replicated store data for the RMW merge
  always_comb begin
    be    = 4'hF;
    wdata = bus.din;
    unique case (1'b1)
      is_byte: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.din[7:0]}};
      end
      is_half: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.din[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = bus.din;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign half_v = lane[1] ? w[31:16] : w[15:0];
  assign byte_v = w[8*lane +: 8];

  always_comb begin
    dout_d = '0;
    if (ready && !mis) begin
      unique case (1'b1)
        is_byte: dout_d = is_sgn ? {{24{byte_v[7]}}, byte_v}
                                 : {24'b0, byte_v};
        is_half: dout_d = is_sgn ? {{16{half_v[15]}}, half_v}
                                 : {16'b0, half_v};
        default: dout_d = w;
      endcase
    end
  end

  assign bus.dout     = dout_d;
  assign bus.busy     = (state_q == CLEAR);
  assign bus.addr_err = (bus.MemWrite || bus.MemRead) && mis && ready;
endmodule

// File: tb/tb_dm_subword.sv
// Randomised and directed checks of dm_subword against a
// behavioural memory model.
module tb_dm_subword;
  localparam int NW = 1024;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int unsigned ref_mem [NW];
  logic [31:0] q;

  dm_subword_if bus ();

  dm_subword #(.DEPTH_LOG2(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int kind(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 2;
    if (op == 3'd3 || op == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] op, input int unsigned a);
    return (a % kind(op)) != 0;
  endfunction

  function automatic int unsigned m_load(input logic [2:0] op,
                                         input int unsigned a);
    int unsigned wv, v, sh;
    int k;
    k  = kind(op);
    if (m_mis(op, a)) return 0;
    wv = ref_mem[(a / 4) % NW];
    if (k == 4) return wv;
    sh = 8 * (a % 4);
    if (k == 2) begin
      v = (wv >> sh) % 65536;
      if (op == 3'd2 && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = (wv >> sh) % 256;
      if (op == 3'd4 && v >= 128) v = v + 32'hFFFFFF00;
    end
    return v;
  endfunction

  task automatic m_store(input logic [2:0] op, input int unsigned a,
                         input int unsigned d);
    int unsigned i, sh, mask;
    int k;
    k = kind(op);
    if (m_mis(op, a)) return;
    i = (a / 4) % NW;
    if (k == 4) begin
      ref_mem[i] = d;
    end else begin
      sh   = 8 * (a % 4);
      mask = ((k == 2) ? 32'hFFFF : 32'hFF) << sh;
      ref_mem[i] = (ref_mem[i] & ~mask) | ((d << sh) & mask);
    end
  endtask

  task automatic acc(input bit we, input bit re, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] qo);
    bus.MemWrite = we;
    bus.MemRead  = re;
    bus.MemOp    = op;
    bus.addr     = a;
    bus.din      = d;
    #2;
    chk("dout", bus.dout, m_load(op, a));
    chk("addr_err", {31'b0, bus.addr_err},
        {31'b0, (we | re) & m_mis(op, a)});
    qo = bus.dout;
    @(posedge clk);
    #1;
    if (we) m_store(op, a, d);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
  endtask

  task automatic do_reset();
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.MemOp    = 3'd0;
    bus.addr     = 32'h2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd1);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_err", {31'b0, bus.addr_err}, 32'd0);
    bus.MemRead = 1'b0;
  endtask

  // Keeps an aligned store asserted for the whole sweep; it must be ignored
  task automatic wait_sweep();
    int n = 0;
    int bad = 0;
    bus.MemWrite = 1'b1;
    bus.MemOp    = 3'd0;
    bus.addr     = 32'h28;
    bus.din      = 32'hCAFEF00D;
    while (bus.busy && n < 2000) begin
      if (bus.dout != 0) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    bus.MemWrite = 1'b0;
    chk("sweep_len", n, NW);
    chk("busy_dout", bad, 0);
    foreach (ref_mem[i]) ref_mem[i] = 0;
  endtask

  initial begin
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemOp    = 3'd0;
    bus.addr     = '0;
    bus.din      = '0;
    reset        = 1'b0;

    do_reset();
    wait_sweep();
    // Store in the very cycle busy falls, then reset clears it
    acc(1, 0, 3'd0, 32'h10, 32'hDEADBEEF, q);
    acc(0, 1, 3'd0, 32'h10, 0, q);
    chk("lw_10", q, 32'hDEADBEEF);
    acc(0, 1, 3'd0, 32'h28, 0, q);
    chk("busy_store_ign", q, 32'h0);

    do_reset();
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    wait_sweep();
    acc(0, 1, 3'd0, 32'h10, 0, q);
    chk("lw_10_clr", q, 32'h0);
    acc(0, 1, 3'd0, 32'h28, 0, q);
    chk("lw_28_clr", q, 32'h0);

    acc(1, 0, 3'd3, 32'h1, 32'h55AA, q);
    acc(1, 0, 3'd3, 32'h3, 32'h80, q);
    acc(0, 1, 3'd0, 32'h0, 0, q);
    chk("sb_lw", q, 32'h8000AA00);
    acc(0, 1, 3'd4, 32'h3, 0, q);
    chk("lb", q, 32'hFFFFFF80);
    acc(0, 1, 3'd3, 32'h3, 0, q);
    chk("lbu", q, 32'h00000080);

    acc(1, 0, 3'd0, 32'h4, 32'hFFFFFFFF, q);
    acc(1, 0, 3'd1, 32'h6, 32'hAB1234, q);
    acc(0, 1, 3'd0, 32'h4, 0, q);
    chk("sh_lw", q, 32'h1234FFFF);
    acc(0, 1, 3'd2, 32'h4, 0, q);
    chk("lh", q, 32'hFFFFFFFF);
    acc(0, 1, 3'd1, 32'h6, 0, q);
    chk("lhu", q, 32'h00001234);

    acc(1, 0, 3'd0, 32'h20, 32'h11111111, q);
    acc(1, 0, 3'd0, 32'h22, 32'h0, q);
    acc(0, 1, 3'd0, 32'h20, 0, q);
    chk("mis_sw_keep", q, 32'h11111111);
    acc(0, 1, 3'd2, 32'h21, 0, q);
    chk("mis_lh", q, 32'h0);

    acc(1, 0, 3'd0, 32'h1000, 32'h5, q);
    acc(0, 1, 3'd0, 32'h0, 0, q);
    chk("alias", q, 32'h5);
    acc(1, 0, 3'd7, 32'h30, 32'h89ABCDEF, q);
    acc(0, 1, 3'd7, 32'h30, 0, q);
    chk("op7", q, 32'h89ABCDEF);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF000);
      acc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), a, $urandom, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
